// File: rtl/rf_pkg.sv
// Shared widths and the writeback entry type for the register file write queue.
package rf_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // Destination index plus result; 'reg' is reserved, hence waddr.
  typedef struct packed {
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_bypass_match.sv
// Youngest-match search for one lookup index over age-ordered candidates.
module rf_bypass_match
  import rf_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  wb_entry_t [N-1:0]    cand,
  input  logic      [N-1:0]    cand_vld,
  input  logic      [ADDR_W-1:0] idx,
  output logic                 hit,
  output logic      [DATA_W-1:0] data
);

  // Index 0 is the oldest candidate; later matches overwrite earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (idx != REG_ZERO) begin
      for (int i = 0; i < int'(N); i++) begin
        if (cand_vld[i] && (cand[i].waddr == idx)) begin
          hit  = 1'b1;
          data = cand[i].data;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// In-order writeback queue in front of the register file write port, with
// bypass lookup over pending and in-flight writes.
module regfile_write_queue
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [ADDR_W-1:0]            alu_reg,
  input  logic [DATA_W-1:0]            alu_data,
  output logic                         alu_ready,
  input  logic                         mem_valid,
  input  logic [ADDR_W-1:0]            mem_reg,
  input  logic [DATA_W-1:0]            mem_data,
  output logic                         mem_ready,
  input  logic                         drain_en,
  output logic                         RegWrite,
  output logic [ADDR_W-1:0]            Write_reg,
  output logic [DATA_W-1:0]            Write_data,
  input  logic [ADDR_W-1:0]            rs,
  input  logic [ADDR_W-1:0]            rt,
  output logic                         fwd_hit1,
  output logic [DATA_W-1:0]            fwd_data1,
  output logic                         fwd_hit2,
  output logic [DATA_W-1:0]            fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  wb_entry_t             buf_q [DEPTH];
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, empty_q;
  logic                  regwrite_q;
  wb_entry_t             out_q;

  wb_entry_t             in_entry;
  logic                  accept, push, pop;

  wb_entry_t [DEPTH:0]   cand;
  logic      [DEPTH:0]   cand_vld;
  logic      [PTR_W-1:0] slot;

  // mem wins arbitration; ready is independent of drain_en.
  always_comb begin
    mem_ready = !full_q;
    alu_ready = !full_q && !mem_valid;
    in_entry  = mem_valid ? wb_entry_t'({mem_reg, mem_data}) : wb_entry_t'({alu_reg, alu_data});
    accept    = (mem_valid || alu_valid) && !full_q;
    push      = accept && (in_entry.waddr != REG_ZERO);
    pop       = drain_en && !empty_q;
    count_d   = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      regwrite_q <= 1'b0;
      out_q      <= '0;
    end else begin
      if (push) begin
        buf_q[tail_q] <= in_entry;
        tail_q        <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        out_q  <= buf_q[head_q];
        head_q <= head_q + PTR_W'(1);
      end
      regwrite_q <= pop;
      count_q    <= count_d;
      full_q     <= (count_d == CNT_W'(DEPTH));
      empty_q    <= (count_d == '0);
    end
  end

  // Age order for bypass: output register oldest, then queue head to tail.
  always_comb begin
    cand        = '0;
    cand_vld    = '0;
    slot        = '0;
    cand[0]     = out_q;
    cand_vld[0] = regwrite_q;
    for (int k = 0; k < int'(DEPTH); k++) begin
      slot          = head_q + PTR_W'(k);
      cand[k+1]     = buf_q[slot];
      cand_vld[k+1] = (CNT_W'(k) < count_q);
    end
  end

  rf_bypass_match #(
    .N (DEPTH + 1)
  ) u_match_rs (
    .cand     (cand),
    .cand_vld (cand_vld),
    .idx      (rs),
    .hit      (fwd_hit1),
    .data     (fwd_data1)
  );

  rf_bypass_match #(
    .N (DEPTH + 1)
  ) u_match_rt (
    .cand     (cand),
    .cand_vld (cand_vld),
    .idx      (rt),
    .hit      (fwd_hit2),
    .data     (fwd_data2)
  );

  assign RegWrite   = regwrite_q;
  assign Write_reg  = out_q.waddr;
  assign Write_data = out_q.data;
  assign count      = count_q;
  assign full       = full_q;
  assign empty      = empty_q;

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Writer-side front end for the 16x16 register file write port: buffers writeback results from ALU and load producers in order and drives RegWrite/Write_reg/Write_data one write per cycle.
- Supplies bypass data for pending, not-yet-committed writes so decode reads stay coherent while writes queue behind a drain stall.
- Sits between execute/memory stages and the register file.

Parameters:
DATA_W, 16, data width of a register
ADDR_W, 4, register index width (16 registers)
DEPTH, 4, queue entries (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
alu_valid  in  1  ALU result offered
alu_reg  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU offer accepted this cycle
mem_valid  in  1  load result offered
mem_reg  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
mem_ready  out  1  load offer accepted this cycle
drain_en  in  1  1 = queue may commit a write this cycle
RegWrite  out  1  register file write enable (registered)
Write_reg  out  ADDR_W  register file write index (registered)
Write_data  out  DATA_W  register file write data (registered)
rs  in  ADDR_W  bypass lookup index 1
rt  in  ADDR_W  bypass lookup index 2
fwd_hit1  out  1  pending write exists for rs
fwd_data1  out  DATA_W  youngest pending data for rs
fwd_hit2  out  1  pending write exists for rt
fwd_data2  out  DATA_W  youngest pending data for rt
count  out  $clog2(DEPTH+1)  queue occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (async, rst=1): queue empty, pointers 0, count=0, full=0, empty=1, RegWrite=0, Write_reg=0, Write_data=0, fwd_hit*=0, fwd_data*=0. Reset mid-operation discards all pending writes; nothing reaches the register file.
- Arbitration: at most one enqueue per cycle. mem has priority: mem_ready = !full; alu_ready = !full && !mem_valid. Handshake completes on valid && ready at rising edge. Producers hold valid/reg/data until ready.
- R0 filter: an accepted offer with reg==0 completes its handshake but is dropped. Not enqueued; count unchanged; never forwarded.
- Drain: each edge with drain_en=1 and queue non-empty pops the head into the output register: RegWrite<=1, Write_reg<=head reg, Write_data<=head data. Otherwise RegWrite<=0; Write_reg/Write_data hold.
- Latency: accept at edge N; earliest RegWrite=1 in cycle after edge N+1; register file written at edge N+2. Throughput 1 write/cycle.
- Simultaneous enqueue and pop: both happen; count unchanged. When full, no enqueue even if a pop occurs that cycle. ready never depends on drain_en.
- Order: strict FIFO, duplicates to the same register kept. Pointers wrap modulo DEPTH.
- Bypass (combinational): search queue entries plus the output register while RegWrite=1. Youngest match wins, with the output register oldest. rs/rt==0 gives hit=0, data=0. No hit gives data=0. Same-cycle incoming producer data is not searched.
- count/full/empty are registered, consistent with queue state after each edge.

Decomposition:
- Shared package rf_pkg: DATA_W, ADDR_W, REG_ZERO constant, and a wb_entry_t struct {reg, data}.
- Sub-module rf_bypass_match: combinational youngest-match search over DEPTH+1 entries for one index. Instantiated twice, for rs and rt.

Test Plan:
- Reset then mem_valid reg=3 data=0x0032, drain_en=1 -> mem_ready=1; RegWrite=1, Write_reg=3, Write_data=0x0032 exactly one cycle after acceptance edge; empty=1 afterwards.
- Same-cycle alu_valid reg=5 data=0x00AA and mem_valid reg=6 data=0x00BB, drain_en=1 -> mem accepted first, alu_ready=0 that cycle. Next cycle alu accepted. Commits in order: reg6 then reg5.
- drain_en=0, offer 5 writes (reg 1..5 data 0x11..0x55) -> 4 accepted, full=1, count=4, ready=0 on 5th. drain_en=1 -> commits reg1..4 in order, then reg5 accepted.
- drain_en=0, enqueue reg7=0x0100 then reg7=0x0200; rs=7, rt=2 -> fwd_hit1=1, fwd_data1=0x0200, fwd_hit2=0.
- Offer reg=0 data=0xFFFF -> ready=1, count stays 0, no RegWrite pulse, rs=0 gives fwd_hit1=0.
- Enqueue 3 writes with drain_en=0, assert rst asynchronously mid-cycle -> outputs zero immediately. After release, count=0, no RegWrite.
